seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle 16-bit shifter: one 1-bit step per clock for SRL, SLA (with
// overflow detect) and ROL; mode 2'b11 passes the operand straight through.
module seq_shifter #(
    parameter logic [1:0] SRL = 2'b00,
    parameter logic [1:0] SLA = 2'b01,
    parameter logic [1:0] ROL = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] Shift_In,
    input  logic [3:0]  Shift_Val,
    input  logic [1:0]  Mode,
    output logic [15:0] Shift_Out,
    output logic        Busy,
    output logic        Done,
    output logic        Ovf
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [DATA_W-1:0]   data_q;
    logic [3:0]          cnt_q;
    logic [1:0]          mode_q;
    logic                ovf_q;

    function automatic logic [DATA_W-1:0] shift_step(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (m == SRL)
            r = {1'b0, d[DATA_W-1:1]};
        else if (m == SLA)
            r = {d[DATA_W-2:0], 1'b0};
        else if (m == ROL)
            r = {d[DATA_W-2:0], d[DATA_W-1]};
        return r;
    endfunction

    // Overflow of a left arithmetic step: the sign bit is about to be lost.
    function automatic logic sla_ovf(input logic [1:0] m,
                                     input logic [DATA_W-1:0] d);
        return (m == SLA) && (d[DATA_W-1] != d[DATA_W-2]);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ((Shift_Val == 4'd0) || (Mode == 2'b11)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (cnt_q == 4'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ((Shift_Val == 4'd0) || (Mode == 2'b11)) ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are latched only on an accepted Start, so input changes
    // during SHIFT cannot disturb the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            data_q <= Shift_In;
            cnt_q  <= Shift_Val;
            mode_q <= Mode;
            ovf_q  <= 1'b0;
        end else if (state == SHIFT) begin
            data_q <= shift_step(mode_q, data_q);
            cnt_q  <= cnt_q - 4'd1;
            if (sla_ovf(mode_q, data_q))
                ovf_q <= 1'b1;
        end
    end

    assign Shift_Out = data_q;
    assign Ovf       = ovf_q;

endmodule
